// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed 4-digit FND scan controller with double-buffered display data
// Ports: i_clk, i_rst_n (async active-low); i_en scan enable; i_load strobes i_data/i_dp into
// the pending shadow; o_cnt4 digit index; o_fndselect one-hot digit enable; o_fndfont active-low
// segments {dp,g,f,e,d,c,b,a}; o_pend pending shadow not yet committed.
// Optional leading-zero blanking when FND_LZB_EN is defined.
module fnd_scan_ctrl #(
    parameter int TICK_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic [3:0]  i_dp,
    output logic [1:0]  o_cnt4,
    output logic [3:0]  o_fndselect,
    output logic [7:0]  o_fndfont,
    output logic        o_pend
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [1:0] cnt_nx;
    logic [15:0] disp_data, pend_data;
    logic [3:0] disp_dp, pend_dp;
    logic [3:0] nib;
    logic tick, run, commit, blank;
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            presc     <= '0;
            o_cnt4    <= 2'd0;
            disp_data <= '0;
            disp_dp   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            o_pend    <= 1'b0;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            o_cnt4 <= cnt_nx;
            if (commit) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
            end
            if (i_load) begin
                pend_data <= i_data;
                pend_dp   <= i_dp;
            end
            // a load coinciding with a commit becomes the next pending value
            o_pend <= i_load | (o_pend & ~commit);
        end
    end
    always_comb begin
        state_nx = i_en ? SCAN : IDLE;
        run      = (state == SCAN) && i_en;
        tick     = (state == SCAN) && (presc == LAST);
        presc_nx = run ? (tick ? '0 : presc + 1'b1) : '0;
        cnt_nx   = run ? o_cnt4 + 2'(tick) : 2'd0;
        // commit only at frame boundaries while scanning so a frame never mixes old and new data
        commit   = o_pend && ((state == IDLE) || (tick && o_cnt4 == 2'd3));
    end
    always_comb begin
        nib = disp_data[{o_cnt4, 2'b00} +: 4];
`ifdef FND_LZB_EN
        blank = (o_cnt4 == 2'd3 && disp_data[15:12] == '0) ||
                (o_cnt4 == 2'd2 && disp_data[15:8] == '0) ||
                (o_cnt4 == 2'd1 && disp_data[15:4] == '0);
`else
        blank = 1'b0;
`endif
        o_fndselect = (state == SCAN) ? 4'b0001 << o_cnt4 : 4'b0000;
        o_fndfont   = (state == SCAN) ? {~disp_dp[o_cnt4], blank ? 7'h7F : seg7(nib)} : 8'hFF;
    end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed plus randomized check of fnd_scan_ctrl against a cycle-count reference model
module tb_fnd_scan_ctrl;
    localparam int TD = 4;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_load = 1'b0;
    logic [15:0] i_data = '0;
    logic [3:0]  i_dp = '0;
    logic [1:0]  o_cnt4;
    logic [3:0]  o_fndselect;
    logic [7:0]  o_fndfont;
    logic        o_pend;
    int tests = 0;
    int fails = 0;
    logic [7:0] font_tab [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    bit          m_on;
    int          m_n;
    logic [15:0] m_data, m_pdata;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pend;

    fnd_scan_ctrl #(.TICK_DIV(TD)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_load(i_load),
        .i_data(i_data), .i_dp(i_dp), .o_cnt4(o_cnt4), .o_fndselect(o_fndselect),
        .o_fndfont(o_fndfont), .o_pend(o_pend)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int m_digit();
        return m_on ? (m_n / TD) % 4 : 0;
    endfunction

    function automatic logic [7:0] m_font();
        int d = m_digit();
        logic [15:0] upper = m_data >> (4 * d);
        logic [6:0] seg = font_tab[upper[3:0]][6:0];
`ifdef FND_LZB_EN
        if (d > 0 && upper == 16'h0) seg = 7'h7F;
`endif
        return m_on ? {~m_dp[d], seg} : 8'hFF;
    endfunction

    task automatic model_reset();
        m_on = 0; m_n = 0; m_data = '0; m_pdata = '0; m_dp = '0; m_pdp = '0; m_pend = 0;
    endtask

    task automatic model_step();
        bit commit = m_pend && (m_on ? (m_n % (4 * TD) == 4 * TD - 1) : 1'b1);
        if (commit) begin
            m_data = m_pdata;
            m_dp   = m_pdp;
        end
        if (i_load) begin
            m_pdata = i_data;
            m_pdp   = i_dp;
            m_pend  = 1;
        end else if (commit) m_pend = 0;
        if (m_on && i_en) m_n++;
        else begin
            m_on = i_en;
            m_n  = 0;
        end
    endtask

    task automatic check_all();
        check("cnt4", {6'd0, o_cnt4}, 8'(m_digit()));
        check("select", {4'd0, o_fndselect}, m_on ? 8'(1 << m_digit()) : 8'h00);
        check("font", o_fndfont, m_font());
        check("pend", {7'd0, o_pend}, {7'd0, m_pend});
    endtask

    task automatic cycle();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        i_data = d;
        i_dp   = p;
        i_load = 1'b1;
        cycle();
        i_load = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        repeat (2) begin
            @(negedge i_clk);
            check_all();
        end
        i_rst_n = 1'b1;
        run(3);
        load(16'h1234, 4'b0000);
        run(2);
        i_en = 1'b1;
        cycle();
        check("first_digit_font", o_fndfont, 8'h99);
        check("first_digit_sel", {4'd0, o_fndselect}, 8'h01);
        run(8);
        load(16'hABCD, 4'b0000);
        run(30);
        begin
            int guard = 0;
            while (m_digit() != 2 && guard < 4 * TD) begin
                cycle();
                guard++;
            end
            check("reach_digit2", 8'(m_digit()), 8'd2);
        end
        i_en = 1'b0;
        cycle();
        check("off_select", {4'd0, o_fndselect}, 8'h00);
        check("off_font", o_fndfont, 8'hFF);
        i_en = 1'b1;
        run(10);
        i_en = 1'b0;
        run(1);
        load(16'h0000, 4'b0001);
        run(2);
        i_en = 1'b1;
        cycle();
        check("dp_digit0", o_fndfont, 8'h40);
        run(15);
        load(16'h0007, 4'b0000);
        run(40);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            i_en   = ($urandom_range(0, 9) != 0);
            i_load = ($urandom_range(0, 5) == 0);
            i_data = 16'($urandom) & mask;
            i_dp   = 4'($urandom);
            cycle();
        end
        i_load = 1'b0;
        i_en = 1'b1;
        load(16'h5A3C, 4'b1010);
        run(23);
        #2 i_rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge i_clk);
        check_all();
        i_rst_n = 1'b1;
        run(12);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
